// File: rtl/volume_ramp_control_pkg.sv
// volume_pkg: shared types, default widths and saturation helper for the volume stage
package volume_pkg;
  typedef enum logic [1:0] {STEADY, RAMP_UP, RAMP_DOWN} ramp_state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_VOL_W = 4;
  localparam int PROD_W = DEF_DATA_W + DEF_VOL_W + 1;
  // Clamp x into the signed range of a w-bit word; the caller truncates to w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : (x < lo ? lo : x);
  endfunction
endpackage

// File: rtl/volume_ramp_control_if.sv
// volume_ramp_control_if: input/output frame streams with valid/ready handshakes
//   in_data/in_valid/in_ready    : upstream frame stream, channel 0 in LSBs
//   out_data/out_valid/out_ready : downstream scaled frame stream
//   master drives frames in and accepts results; slave is the volume stage
interface volume_ramp_control_if import volume_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CHANNELS = 2
);
  logic [CHANNELS*DATA_W-1:0] in_data;
  logic [CHANNELS*DATA_W-1:0] out_data;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave(input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/volume_ramp_control_gain_slew.sv
// volume_gain_slew: slews the applied gain toward the target one step per RAMP_STEP accepted frames
//   target       : desired gain (already forced to 0 by mute)
//   frame_accept : a frame is accepted this cycle
//   gain_now     : gain applied to frames accepted this cycle
//   ramping      : high while the slew FSM is not STEADY
module volume_gain_slew import volume_pkg::*; #(
  parameter int VOL_W = DEF_VOL_W,
  parameter int RAMP_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VOL_W-1:0] target,
  input  logic             frame_accept,
  output logic [VOL_W-1:0] gain_now,
  output logic             ramping
);
  localparam int CW = RAMP_STEP > 1 ? $clog2(RAMP_STEP) : 1;
  ramp_state_t state_q, state_d, want;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VOL_W-1:0] gain_q, gain_d;
  logic last_frame;
  assign last_frame = cnt_q == CW'(RAMP_STEP - 1);
  // Entering a ramp or reversing it only restarts the count; frames are counted
  // once the FSM already points toward the target.
  always_comb begin
    want = target > gain_q ? RAMP_UP : RAMP_DOWN;
    state_d = state_q;
    cnt_d = cnt_q;
    gain_d = gain_q;
    if (target == gain_q) begin
      state_d = STEADY;
      cnt_d = '0;
    end else if (state_q != want) begin
      state_d = want;
      cnt_d = '0;
    end else if (frame_accept) begin
      cnt_d = last_frame ? '0 : cnt_q + 1'b1;
      gain_d = !last_frame ? gain_q : state_q == RAMP_UP ? gain_q + 1'b1 : gain_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STEADY;
      cnt_q <= '0;
      gain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gain_q <= gain_d;
    end
  end
  assign gain_now = gain_q;
  assign ramping = state_q != STEADY;
endmodule

// File: rtl/volume_ramp_control.sv
// volume_ramp_control: multi-channel volume stage with slewed shared gain and saturating 2-stage pipeline
//   clk, reset   : clock, synchronous active-high reset
//   volume_level : target gain, mute forces the target to 0
//   bus          : slave side of the in/out frame streams
//   gain_now     : gain applied to frames accepted this cycle
//   ramping      : high while gain_now is moving toward the target
module volume_ramp_control import volume_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int VOL_W = DEF_VOL_W,
  parameter int CHANNELS = 2,
  parameter int RAMP_STEP = 4,
  parameter int BOOST_SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VOL_W-1:0]       volume_level,
  input  logic                   mute,
  volume_ramp_control_if.slave   bus,
  output logic [VOL_W-1:0]       gain_now,
  output logic                   ramping
);
  localparam int PW = DATA_W + VOL_W + 1;
  logic advance, accept;
  logic s1_valid_q, out_valid_q;
  // Both stages move together, so the pipeline only stalls when the held output is refused.
  assign advance = !out_valid_q | bus.out_ready;
  assign accept = bus.in_valid & advance;
  assign bus.in_ready = advance;
  assign bus.out_valid = out_valid_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= bus.in_valid;
      out_valid_q <= s1_valid_q;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [63:0] scaled;
    logic [DATA_W-1:0] res_q, res_d;
    assign prod_d = PW'($signed(bus.in_data[c*DATA_W +: DATA_W])) * PW'($signed({1'b0, gain_now}));
    // Signed arithmetic right shift floors toward minus infinity.
    assign scaled = (64'(prod_q) <<< BOOST_SHIFT) >>> VOL_W;
    assign res_d = DATA_W'(sat_signed(scaled, DATA_W));
    always_ff @(posedge clk) begin
      if (reset) begin
        prod_q <= '0;
        res_q <= '0;
      end else if (advance) begin
        if (bus.in_valid) prod_q <= prod_d;
        if (s1_valid_q) res_q <= res_d;
      end
    end
    assign bus.out_data[c*DATA_W +: DATA_W] = res_q;
  end
  volume_gain_slew #(.VOL_W(VOL_W), .RAMP_STEP(RAMP_STEP)) u_slew (
    .clk,
    .reset,
    .target(mute ? '0 : volume_level),
    .frame_accept(accept),
    .gain_now,
    .ramping
  );
endmodule

// File: tb/tb_volume_ramp_control.sv
// tb_volume_ramp_control: three volume stages (step 1, step 4, boost 1) driven alike and checked against a reference model
module tb_volume_ramp_control;
  localparam int RS[3] = '{1, 4, 1};
  localparam int BS[3] = '{0, 0, 1};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic d_rst, d_mute, d_valid, d_ordy;
  logic [3:0] d_vol;
  logic [31:0] d_data;
  logic [31:0] od[3];
  logic ov[3], ir[3], rp[3];
  logic [3:0] gn[3];
  volume_ramp_control_if ia();
  volume_ramp_control_if ib();
  volume_ramp_control_if ic();
  assign ia.in_data = d_data;
  assign ia.in_valid = d_valid;
  assign ia.out_ready = d_ordy;
  assign ib.in_data = d_data;
  assign ib.in_valid = d_valid;
  assign ib.out_ready = d_ordy;
  assign ic.in_data = d_data;
  assign ic.in_valid = d_valid;
  assign ic.out_ready = d_ordy;
  assign od[0] = ia.out_data;
  assign od[1] = ib.out_data;
  assign od[2] = ic.out_data;
  assign ov[0] = ia.out_valid;
  assign ov[1] = ib.out_valid;
  assign ov[2] = ic.out_valid;
  assign ir[0] = ia.in_ready;
  assign ir[1] = ib.in_ready;
  assign ir[2] = ic.in_ready;
  volume_ramp_control #(.RAMP_STEP(1), .BOOST_SHIFT(0)) ua (.clk, .reset(d_rst), .volume_level(d_vol),
    .mute(d_mute), .bus(ia), .gain_now(gn[0]), .ramping(rp[0]));
  volume_ramp_control #(.RAMP_STEP(4), .BOOST_SHIFT(0)) ub (.clk, .reset(d_rst), .volume_level(d_vol),
    .mute(d_mute), .bus(ib), .gain_now(gn[1]), .ramping(rp[1]));
  volume_ramp_control #(.RAMP_STEP(1), .BOOST_SHIFT(1)) uc (.clk, .reset(d_rst), .volume_level(d_vol),
    .mute(d_mute), .bus(ic), .gain_now(gn[2]), .ramping(rp[2]));
  int total = 0, bad = 0, acc_cnt = 0;
  int g[3], c[3], s[3];
  logic [31:0] q[3][$];
  logic [31:0] outs[3][$];
  logic [31:0] last[3];
  logic rst_prev;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Reference scaling: gain/16 times 2^boost, floored, clamped to 16-bit signed.
  function automatic logic [31:0] expf(logic [31:0] f, int gain, int bs);
    logic [31:0] r;
    longint p, v;
    r = '0;
    for (int ch = 0; ch < 2; ch++) begin
      p = longint'($signed(f[ch*16 +: 16])) * gain * (longint'(1) << bs);
      v = p / 16;
      if (p < 0 && p % 16 != 0) v = v - 1;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      r[ch*16 +: 16] = 16'(v);
    end
    return r;
  endfunction
  // One cycle: check registered outputs, score the output handshake, log accepted
  // frames with the gain they must use, then advance the gain model for this edge.
  task automatic tick();
    int t, dir;
    logic a;
    #1;
    t = d_mute ? 0 : int'(d_vol);
    for (int i = 0; i < 3; i++) begin
      chk("gain", 32'(gn[i]), 32'(g[i]));
      chk("ramping", 32'(rp[i]), 32'(s[i] != 0));
      if (rst_prev) chk("rst_ov", 32'(ov[i]), 0);
      if (ov[i] && q[i].size() == 0) chk("spurious", 32'(ov[i]), 0);
      else if (ov[i]) begin
        chk("data", od[i], q[i][0]);
        if (d_ordy && !d_rst) begin
          last[i] = q[i].pop_front();
          outs[i].push_back(last[i]);
        end
      end
      a = d_valid & ir[i] & !d_rst;
      if (a) begin
        q[i].push_back(expf(d_data, g[i], BS[i]));
        if (i == 0) acc_cnt++;
      end
      dir = t > g[i] ? 1 : -1;
      if (d_rst) begin
        g[i] = 0; c[i] = 0; s[i] = 0;
        q[i].delete();
      end else if (t == g[i]) begin
        s[i] = 0; c[i] = 0;
      end else if (s[i] != dir) begin
        s[i] = dir; c[i] = 0;
      end else if (a) begin
        if (c[i] == RS[i] - 1) begin
          g[i] += s[i]; c[i] = 0;
        end else c[i]++;
      end
    end
    rst_prev = d_rst;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(int n);
    d_valid = 1'b0;
    repeat (n) tick();
  endtask
  task automatic send(logic [31:0] f);
    d_data = f;
    d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
  endtask
  task automatic drain();
    d_valid = 1'b0;
    for (int k = 0; k < 20 && (q[0].size() + q[1].size() + q[2].size()) != 0; k++) tick();
    chk("drain", 32'(q[0].size() + q[1].size() + q[2].size()), 0);
  endtask
  task automatic do_reset();
    d_rst = 1'b1;
    d_valid = 1'b0;
    tick();
    tick();
    d_rst = 1'b0;
    for (int i = 0; i < 3; i++) outs[i].delete();
  endtask
  initial begin
    logic rst_done;
    d_rst = 1'b1; d_mute = 1'b0; d_valid = 1'b0; d_ordy = 1'b1; d_vol = 4'd15; d_data = '0;
    for (int i = 0; i < 3; i++) begin g[i] = 0; c[i] = 0; s[i] = 0; last[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_prev = 1'b1;
    for (int i = 0; i < 3; i++) chk("rst_data", od[i], 0);
    d_rst = 1'b0;
    idle(1);
    repeat (20) send(32'h4000_4000);
    drain();
    chk("t1_first", outs[0][0], 32'h0000_0000);
    chk("t1_g5", outs[0][5], 32'h1400_1400);
    chk("t1_g15", outs[0][19], 32'h3C00_3C00);
    chk("t1_gain", 32'(gn[0]), 15);
    chk("t1_ramp", 32'(rp[0]), 0);
    send(32'hFFFF_C000);
    drain();
    chk("t2_floor", last[0], 32'hFFFF_C400);
    d_vol = 4'd3;
    do_reset();
    idle(1);
    repeat (6) send(32'h4000_4000);
    idle(10);
    chk("t3_hold", 32'(gn[1]), 1);
    repeat (8) send(32'h4000_4000);
    drain();
    chk("t3_f3", outs[1][3], 32'h0000_0000);
    chk("t3_f4", outs[1][4], 32'h0400_0400);
    chk("t3_f7", outs[1][7], 32'h0400_0400);
    chk("t3_f8", outs[1][8], 32'h0800_0800);
    chk("t3_f12", outs[1][12], 32'h0C00_0C00);
    d_vol = 4'd8;
    do_reset();
    idle(1);
    repeat (10) send(32'h4000_4000);
    chk("t4_gain8", 32'(gn[0]), 8);
    d_mute = 1'b1;
    for (int k = 0; k < 20 && gn[0] != 4'd4; k++) send(32'h2000_E000);
    chk("t4_at4", 32'(gn[0]), 4);
    d_mute = 1'b0;
    send(32'h2000_E000);
    chk("t4_turn", 32'(gn[0]), 4);
    chk("t4_ramp", 32'(rp[0]), 1);
    send(32'h2000_E000);
    chk("t4_up", 32'(gn[0]), 5);
    repeat (10) send(32'h2000_E000);
    d_mute = 1'b1;
    repeat (14) send(32'h2000_E000);
    drain();
    chk("t4_zero", last[0], 32'h0000_0000);
    chk("t4_gain0", 32'(gn[0]), 0);
    d_mute = 1'b0;
    d_vol = 4'd15;
    do_reset();
    idle(1);
    repeat (20) send(32'h4000_4000);
    drain();
    chk("t5_gain", 32'(gn[2]), 15);
    send(32'h9000_7000);
    chk("t5_lat1", 32'(ov[2]), 0);
    idle(1);
    chk("t5_lat2", 32'(ov[2]), 1);
    chk("t5_sat", od[2], 32'h8000_7FFF);
    drain();
    send(32'h0100_0100);
    drain();
    chk("t5_boost", last[2], 32'h01E0_01E0);
    do_reset();
    acc_cnt = 0;
    rst_done = 1'b0;
    for (int cyc = 0; cyc < 6000 && acc_cnt < 1000; cyc++) begin
      d_valid = $urandom_range(0, 3) != 0;
      d_ordy = $urandom_range(0, 2) != 0;
      d_data = $urandom;
      if ($urandom_range(0, 49) == 0) d_vol = 4'($urandom);
      if ($urandom_range(0, 99) == 0) d_mute = !d_mute;
      if (!rst_done && acc_cnt >= 500) begin
        d_rst = 1'b1;
        tick();
        d_rst = 1'b0;
        rst_done = 1'b1;
        chk("t6_rst_ov", 32'(ov[0]), 0);
        chk("t6_rst_g", 32'(gn[0]), 0);
      end else tick();
    end
    chk("t6_frames", 32'(acc_cnt >= 1000), 1);
    d_ordy = 1'b1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
